// File: rtl/bus_control_sequencer_pkg.sv
// Shared definitions for the mini-SRC control sequencer: opcodes, bus-source
// indices, ALU codes, FSM states and opcode classification.
package bus_control_sequencer_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bus-source indices above the GPRs, in encoder order
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHI    = 5'd18;
  localparam logic [4:0] SRC_ZLO    = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
    ALU_AND = 4'd3, ALU_OR  = 4'd4, ALU_INC = 4'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_ADDI, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILL
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: classify = CL_ALU;
      OP_ADDI: classify = CL_ADDI;
      OP_LD:   classify = CL_LD;
      OP_ST:   classify = CL_ST;
      OP_NOP:  classify = CL_NOP;
      OP_HALT: classify = CL_HALT;
      default: classify = CL_ILL;
    endcase
  endfunction

  function automatic alu_op_e alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      OP_OR:   alu_of = ALU_OR;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bus_control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/run/memory handshake in, bus and load strobes out.
interface bus_control_sequencer_if #(
  parameter int NUM_GPR = 16,
  parameter int NUM_SRC = 24
);
  logic               run;
  logic [31:0]        ir;
  logic               mem_done;
  logic [NUM_SRC-1:0] bus_src;
  logic [NUM_GPR-1:0] reg_in;
  logic               pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
  logic               mdr_sel;
  logic [3:0]         alu_op;
  logic               mem_read, mem_write;
  logic [2:0]         step;
  logic               halted, illegal, mem_error;

  modport master (
    input  run, ir, mem_done,
    output bus_src, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, mdr_sel,
           alu_op, mem_read, mem_write, step, halted, illegal, mem_error
  );

  modport slave (
    output run, ir, mem_done,
    input  bus_src, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, mdr_sel,
           alu_op, mem_read, mem_write, step, halted, illegal, mem_error
  );
endinterface

// File: rtl/bus_control_sequencer_reg_select_decoder.sv
// Register index + enable to one-hot select; shared by GPR bus sourcing and GPR loads.
module reg_select_decoder #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/bus_control_sequencer.sv
// mini-SRC control-step sequencer: fetch T0-T2, execute T3-T7, Moore outputs
// decoded from the registered step and the current IR.
module bus_control_sequencer
  import bus_control_sequencer_pkg::*;
#(
  parameter int NUM_GPR     = 16,
  parameter int NUM_SRC     = 24,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                     clock,
  input  logic                     clear_n,
  bus_control_sequencer_if.master  bus
);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e          state_q, state_d, end_next;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            mem_error_q, mem_error_d;
  logic            in_wait;

  logic [4:0]      op;
  logic [3:0]      ra, rb, rc;
  op_class_e       cls;
  logic            unused_ir;

  assign op        = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];
  assign cls       = classify(op);
  assign end_next  = bus.run ? ST_T0 : ST_IDLE;

  assign in_wait = (state_q == ST_T1) ||
                   (state_q == ST_T6 && cls == CL_LD) ||
                   (state_q == ST_T7 && cls == CL_ST);

  always_comb begin
    state_d     = state_q;
    mem_error_d = mem_error_q;
    wd_cnt_d    = '0;
    case (state_q)
      ST_IDLE: if (bus.run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   if (bus.mem_done) state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CL_ALU, CL_ADDI, CL_LD, CL_ST: state_d = ST_T4;
          CL_HALT: state_d = ST_HALT;
          default: state_d = end_next;
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (cls == CL_LD || cls == CL_ST) ? ST_T6 : end_next;
      ST_T6:   if (cls == CL_ST || bus.mem_done) state_d = ST_T7;
      ST_T7:   if (cls == CL_LD || bus.mem_done) state_d = end_next;
      default: state_d = state_q;
    endcase
    // Watchdog: counter starts at zero on wait entry, overrides the step on expiry
    if (in_wait && !bus.mem_done) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (MEM_TIMEOUT > 0 && wd_cnt_q == CW'(MEM_TIMEOUT - 1)) begin
        state_d     = ST_HALT;
        mem_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      wd_cnt_q    <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Output decode: one bus source index (GPR or special) plus one GPR load
  logic       src_en, ld_en;
  logic [4:0] src_idx;
  logic       pc_in, ir_in, mar_in, mdr_in, y_in, z_in, mdr_sel;
  logic       mem_read, mem_write, illegal;
  alu_op_e    alu;

  always_comb begin
    src_en = 1'b0; src_idx = '0; ld_en = 1'b0;
    pc_in = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
    mdr_sel = 1'b0; mem_read = 1'b0; mem_write = 1'b0; illegal = 1'b0; alu = ALU_NOP;
    case (state_q)
      ST_T0: begin src_en = 1'b1; src_idx = SRC_PC; mar_in = 1'b1; z_in = 1'b1; alu = ALU_INC; end
      ST_T1: begin
        src_en = 1'b1; src_idx = SRC_ZLO; pc_in = 1'b1;
        mem_read = 1'b1; mdr_sel = 1'b1; mdr_in = 1'b1;
      end
      ST_T2: begin src_en = 1'b1; src_idx = SRC_MDR; ir_in = 1'b1; end
      ST_T3: begin
        if (cls inside {CL_ALU, CL_ADDI, CL_LD, CL_ST}) begin
          src_en = 1'b1; src_idx = {1'b0, rb}; y_in = 1'b1;
        end
        illegal = (cls == CL_ILL);
      end
      ST_T4: begin
        src_en = 1'b1; z_in = 1'b1;
        if (cls == CL_ALU) begin src_idx = {1'b0, rc}; alu = alu_of(op); end
        else               begin src_idx = SRC_C;      alu = ALU_ADD;    end
      end
      ST_T5: begin
        src_en = 1'b1; src_idx = SRC_ZLO;
        if (cls == CL_LD || cls == CL_ST) mar_in = 1'b1;
        else                              ld_en  = 1'b1;
      end
      ST_T6: begin
        mdr_in = 1'b1;
        if (cls == CL_LD) begin mem_read = 1'b1; mdr_sel = 1'b1; end
        else              begin src_en = 1'b1; src_idx = {1'b0, ra}; end
      end
      ST_T7: begin
        if (cls == CL_LD) begin src_en = 1'b1; src_idx = SRC_MDR; ld_en = 1'b1; end
        else              mem_write = 1'b1;
      end
      default: ;
    endcase
  end

  logic [NUM_GPR-1:0] gpr_src, reg_in;
  logic [7:0]         spec_src;

  reg_select_decoder #(.N(NUM_GPR)) u_src_dec (
    .idx(src_idx[3:0]), .en(src_en && !src_idx[4]), .onehot(gpr_src)
  );
  reg_select_decoder #(.N(NUM_GPR)) u_ld_dec (
    .idx(ra), .en(ld_en), .onehot(reg_in)
  );

  assign spec_src = (src_en && src_idx[4]) ? (8'd1 << src_idx[2:0]) : 8'd0;

  assign bus.bus_src   = {spec_src, gpr_src};
  assign bus.reg_in    = reg_in;
  assign bus.pc_in     = pc_in;
  assign bus.ir_in     = ir_in;
  assign bus.mar_in    = mar_in;
  assign bus.mdr_in    = mdr_in;
  assign bus.y_in      = y_in;
  assign bus.z_in      = z_in;
  assign bus.mdr_sel   = mdr_sel;
  assign bus.alu_op    = alu;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.illegal   = illegal;
  assign bus.step      = (state_q inside {[ST_T0:ST_T7]}) ? 3'(state_q - ST_T0) : 3'd0;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.mem_error = mem_error_q;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// micro-step list (waits unrolled by the chosen mem_done delay) and compared cycle by cycle.
module tb_bus_control_sequencer;
  import bus_control_sequencer_pkg::*;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  bus_control_sequencer_if #(.NUM_GPR(16), .NUM_SRC(24)) bus ();

  bus_control_sequencer #(.NUM_GPR(16), .NUM_SRC(24), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .clear_n(clear_n), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         step;
    int         src;
    int         ld;
    logic [5:0] strb;   // {pc_in, ir_in, mar_in, mdr_in, y_in, z_in}
    logic       sel;
    logic [3:0] alu;
    logic       rd, wr, ill, hlt, merr;
    logic       done;
  } cyc_t;

  localparam logic [5:0] S_PC = 6'b100000, S_IR = 6'b010000, S_MAR = 6'b001000;
  localparam logic [5:0] S_MDR = 6'b000100, S_Y = 6'b000010, S_Z = 6'b000001;

  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic cyc_t mk(int step, int src, int ld, logic [5:0] strb, logic sel,
                              logic [3:0] alu, logic rd, logic wr, logic ill);
    cyc_t c;
    c.step = step; c.src = src; c.ld = ld; c.strb = strb; c.sel = sel; c.alu = alu;
    c.rd = rd; c.wr = wr; c.ill = ill; c.hlt = 1'b0; c.merr = 1'b0;
    c.done = 1'($urandom_range(0, 1));
    return c;
  endfunction

  function automatic cyc_t idle_rec();
    return mk(0, -1, -1, 6'b0, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [3:0] alu_ref(input logic [4:0] op);
    case (op)
      5'd4:    return ALU_SUB;
      5'd5:    return ALU_AND;
      5'd6:    return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  task automatic expect_cyc(input string tag, input cyc_t c);
    logic [31:0] es, el;
    es = '0; el = '0;
    if (c.src >= 0) es[c.src] = 1'b1;
    if (c.ld  >= 0) el[c.ld]  = 1'b1;
    check({tag, ".bus_src"}, 32'(bus.bus_src), es);
    check({tag, ".reg_in"},  32'(bus.reg_in),  el);
    check({tag, ".ctl"},
          32'({bus.pc_in, bus.ir_in, bus.mar_in, bus.mdr_in, bus.y_in, bus.z_in, bus.mdr_sel,
               bus.alu_op, bus.mem_read, bus.mem_write, bus.illegal, bus.halted, bus.mem_error}),
          32'({c.strb, c.sel, c.alu, c.rd, c.wr, c.ill, c.hlt, c.merr}));
    check({tag, ".step"}, 32'(bus.step), 32'(c.step));
  endtask

  // Entered and left at a falling edge with the sequencer in T0.
  task automatic do_instr(input string name, input logic [4:0] op, input int ra, input int rb,
                          input int rc, input int d1, input int d2, input bit run_after);
    cyc_t c, h;
    bit   mem_op;
    q.delete();
    bus.ir = {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    mem_op = (op == 5'd0 || op == 5'd2);
    q.push_back(mk(0, 20, -1, S_MAR | S_Z, 1'b0, ALU_INC, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k <= d1; k++) begin
      c = mk(1, 19, -1, S_PC | S_MDR, 1'b1, ALU_NOP, 1'b1, 1'b0, 1'b0);
      c.done = (k == d1);
      q.push_back(c);
    end
    q.push_back(mk(2, 21, -1, S_IR, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
    case (op)
      5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12: begin
        q.push_back(mk(3, rb, -1, S_Y, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
        if (op == 5'd12 || mem_op) q.push_back(mk(4, 23, -1, S_Z, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0));
        else                       q.push_back(mk(4, rc, -1, S_Z, 1'b0, alu_ref(op), 1'b0, 1'b0, 1'b0));
        if (mem_op) q.push_back(mk(5, 19, -1, S_MAR, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
        else        q.push_back(mk(5, 19, ra, 6'b0, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
        if (op == 5'd0) begin
          for (int k = 0; k <= d2; k++) begin
            c = mk(6, -1, -1, S_MDR, 1'b1, ALU_NOP, 1'b1, 1'b0, 1'b0);
            c.done = (k == d2);
            q.push_back(c);
          end
          q.push_back(mk(7, 21, ra, 6'b0, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
        end
        if (op == 5'd2) begin
          q.push_back(mk(6, ra, -1, S_MDR, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0));
          for (int k = 0; k <= d2; k++) begin
            c = mk(7, -1, -1, 6'b0, 1'b0, ALU_NOP, 1'b0, 1'b1, 1'b0);
            c.done = (k == d2);
            q.push_back(c);
          end
        end
      end
      5'd26, 5'd27: q.push_back(idle_rec() );
      default: q.push_back(mk(3, -1, -1, 6'b0, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b1));
    endcase
    if (op == 5'd26 || op == 5'd27) q[q.size()-1].step = 3;
    for (int i = 0; i < q.size(); i++) begin
      expect_cyc($sformatf("%s.T%0d", name, q[i].step), q[i]);
      bus.mem_done = q[i].done;
      bus.run = (i == q.size() - 1) ? run_after : 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    if (op == 5'd27) begin
      h = idle_rec(); h.hlt = 1'b1;
      for (int k = 0; k < 3; k++) begin
        expect_cyc({name, ".halted"}, h);
        bus.run = 1'($urandom_range(0, 1)); bus.mem_done = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
    end else if (!run_after) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        expect_cyc({name, ".idle"}, idle_rec());
        bus.mem_done = 1'($urandom_range(0, 1));
        bus.run = (k == n - 1);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    cyc_t c;
    int   ops [10] = '{0, 2, 3, 4, 5, 6, 12, 26, 31, 7};
    bus.run = 1'b0; bus.ir = '0; bus.mem_done = 1'b0;
    repeat (2) @(negedge clock);
    expect_cyc("reset", idle_rec());
    clear_n = 1'b1;
    @(negedge clock);
    expect_cyc("idle_norun", idle_rec());
    bus.run = 1'b1;
    @(negedge clock);
    expect_cyc("rst.T0", mk(0, 20, -1, S_MAR | S_Z, 1'b0, ALU_INC, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    expect_cyc("rst.T1", mk(1, 19, -1, S_PC | S_MDR, 1'b1, ALU_NOP, 1'b1, 1'b0, 1'b0));
    #2 clear_n = 1'b0;
    #1 expect_cyc("rst.async", idle_rec());
    #1 clear_n = 1'b1;
    @(posedge clock);
    #1 expect_cyc("rst.release", mk(0, 20, -1, S_MAR | S_Z, 1'b0, ALU_INC, 1'b0, 1'b0, 1'b0));
    @(negedge clock);

    do_instr("add",  5'd3,  3, 1, 2, 0, 0, 1'b1);
    do_instr("ld",   5'd0,  5, 2, 4, 1, 3, 1'b1);
    do_instr("st1",  5'd2,  7, 1, 0, 0, 2, 1'b1);
    do_instr("st0",  5'd2,  7, 3, 3, 2, 0, 1'b0);
    do_instr("ill",  5'd31, 1, 2, 3, 0, 0, 1'b1);
    do_instr("addi", 5'd12, 0, 0, 0, 3, 0, 1'b0);
    do_instr("nop",  5'd26, 0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 60; i++)
      do_instr($sformatf("rnd%0d", i), 5'(ops[$urandom_range(0, 9)]),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    do_instr("halt", 5'd27, 0, 0, 0, 1, 0, 1'b1);

    // Watchdog: fetch read never completes
    clear_n = 1'b0;
    @(negedge clock);
    expect_cyc("wd.reset", idle_rec());
    clear_n = 1'b1; bus.run = 1'b1; bus.mem_done = 1'b0;
    @(negedge clock);
    expect_cyc("wd.T0", mk(0, 20, -1, S_MAR | S_Z, 1'b0, ALU_INC, 1'b0, 1'b0, 1'b0));
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      expect_cyc($sformatf("wd.wait%0d", k),
                 mk(1, 19, -1, S_PC | S_MDR, 1'b1, ALU_NOP, 1'b1, 1'b0, 1'b0));
      @(negedge clock);
    end
    c = idle_rec(); c.hlt = 1'b1; c.merr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_cyc("wd.expired", c);
      bus.mem_done = 1'b1;
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
